ncl_wavefront_ctrl: RTL and testbench
=====================================

// Module: ncl_wavefront_ctrl
// PURPOSE
//   Clocked sequencer for one NCL pipeline stage built from threshold gates (thmn/thmnwk cells).
//   Accepts single-rail words on a valid/ready port and encodes each as a dual-rail DATA wavefront.
//   Waits for stage completion, captures the result, then issues a NULL wavefront and waits for NULL completion.
//   Sits between the synchronous test/host logic and the asynchronous NCL netlist.
// PARAMETERS
//   WIDTH       4   data bits; each bit uses one dual-rail pair (t = rail1, f = rail0)
//   TIMEOUT     15  max cycles spent in D_WAIT or N_WAIT before a fault; range 1..255
//   SYNC_STAGES 2   flop depth of the synchronizers on ncl_ko, res_t and res_f; minimum 2
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      input word accepted when in_valid & in_ready
//   in_data    in   WIDTH  single-rail input word
//   ncl_t      out  WIDTH  rail1 drive into the stage
//   ncl_f      out  WIDTH  rail0 drive into the stage
//   ncl_ko     in   1      stage completion: 1 = ready for DATA, 0 = ready for NULL (asynchronous)
//   res_t      in   WIDTH  rail1 of stage result (asynchronous)
//   res_f      in   WIDTH  rail0 of stage result (asynchronous)
//   out_valid  out  1      result word valid
//   out_ready  in   1      result consumed when out_valid & out_ready
//   out_data   out  WIDTH  single-rail result (= res_t captured at DATA completion)
//   err        out  1      sticky fault flag
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - ncl_t = ncl_f = 0 (NULL); out_valid = 0; out_data = 0; err = 0.
//     - State = IDLE; all synchronizer and timeout flops cleared.
//     - Synced ko (ko_s) = 0, so in_ready = 0.
//   in_ready = (state==IDLE) & ko_s & ~out_valid. Combinational; no other term.
//   States:
//     - IDLE: rails NULL. On accept -> D_WAIT.
//       The next edge registers ncl_t = in_data and ncl_f = ~in_data; timeout counter cleared.
//     - D_WAIT: rails hold DATA. Complete when ko_s==0 and, for every bit, res_t_s ^ res_f_s == 1.
//       On completion: out_data <= res_t_s, out_valid <= 1, rails <= NULL, counter cleared, -> N_WAIT.
//     - N_WAIT: rails NULL. Complete when ko_s==1 and res_t_s == res_f_s == 0 -> IDLE.
//     - FAULT: rails NULL, err = 1, in_ready = 0. Only rst_n exits.
//       out_valid/out_data keep their handshake so a pending result can still drain.
//   Timeout: counter increments each cycle in D_WAIT/N_WAIT.
//     When counter == TIMEOUT with completion still false: -> FAULT, err <= 1, rails <= NULL.
//     Completion on the same edge as the timeout wins.
//   Latency:
//     - Accept edge -> DATA on the rails: 1 cycle.
//     - Completion seen on ko_s/res_*_s -> out_valid: 1 cycle.
//     - Raw stage completion -> ko_s: SYNC_STAGES cycles.
//   Output port: out_valid clears on the edge where out_valid & out_ready.
//     A new capture can never coincide with a pending out_valid, because IDLE does not accept while out_valid=1.
//   out_ready may be asserted or held at any time; out_ready with out_valid=0 is ignored.
//   Back-to-back: with out_ready tied to 1, the next word can be accepted on the cycle after N_WAIT completes.
//   Reset mid-operation: the rails go NULL immediately (asynchronously).
//     A captured but unconsumed result is discarded.
// CONFIGURATION
//   NCL_RAIL_CHECK_EN defined:
//     - In D_WAIT and N_WAIT, any bit with res_t_s & res_f_s == 1 (illegal dual-rail state)
//       -> FAULT, err <= 1, on the next edge. This has priority over completion.
//   NCL_RAIL_CHECK_EN undefined:
//     - Illegal rail states are ignored; that bit counts as incomplete.
//     - err is set only by timeout.
// TESTING
//   T1 basic:
//     - Stim: model the stage as a 2-cycle buffer. Drive in_data=4'hA; out_ready=1.
//     - Expect ncl_t=4'hA and ncl_f=4'h5 one cycle after accept.
//     - Expect out_data=4'hA, then rails NULL, then in_ready=1 again.
//     - Expect err=0.
//   T2 backpressure:
//     - Stim: send 4'h3 and 4'hC with out_ready=0 for 10 cycles.
//     - Expect out_valid to hold 4'h3 and in_ready=0 throughout.
//     - Expect 4'hC to be accepted only after out_ready pulses.
//   T3 DATA timeout:
//     - Stim: model holds ncl_ko=1 forever.
//     - Expect FAULT and err=1 exactly TIMEOUT+1 cycles after D_WAIT entry.
//     - Expect rails NULL and in_ready stuck at 0.
//   T4 async reset:
//     - Stim: assert rst_n=0 mid D_WAIT with ncl_t=4'hF.
//     - Expect ncl_t=0 and ncl_f=0 before the next clock edge, and out_valid=0.
//     - Expect normal operation after release once ko_s rises.
//   T5 rail check (NCL_RAIL_CHECK_EN):
//     - Stim: force res_t[1]=res_f[1]=1 during D_WAIT.
//     - Expect err=1 SYNC_STAGES+1 cycles later.
//     - With the macro undefined, expect a timeout instead.
//   T6 completion at limit:
//     - Stim: complete on the same cycle the counter reaches TIMEOUT.
//     - Expect a normal capture with err=0.

Source files
------------

// File: rtl/ncl_wavefront_ctrl.sv
// ncl_wavefront_ctrl
//   Clocked sequencer for a single NCL (NULL Convention Logic) pipeline stage.
//   Each accepted single-rail word is driven into the stage as a dual-rail DATA
//   wavefront. The block waits for DATA completion, captures the result, drives
//   NULL, and then waits for NULL completion before it accepts the next word.
//   The stage's completion and result rails are asynchronous, so each one passes
//   through a SYNC_STAGES-deep synchronizer before use.
//
// Configuration macro: NCL_RAIL_CHECK_EN
//   Defined   - a synced result bit with both rails high is treated as a fault
//               in D_WAIT/N_WAIT, and takes priority over completion.
//   Undefined - such a bit simply counts as incomplete.
//
// Ports
//   clk, rst_n           clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready    input handshake; in_data is the single-rail word
//   ncl_t/ncl_f          rail1/rail0 drive into the stage (all zero = NULL)
//   ncl_ko               stage completion, async (1 = ready for DATA)
//   res_t/res_f          stage result rails, async
//   out_valid/out_ready  result handshake; out_data = res_t captured at completion
//   err                  sticky fault flag (timeout or illegal rail state)
module ncl_wavefront_ctrl #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned TIMEOUT     = 15,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] ncl_t,
  output logic [WIDTH-1:0] ncl_f,
  input  logic             ncl_ko,
  input  logic [WIDTH-1:0] res_t,
  input  logic [WIDTH-1:0] res_f,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             err
);

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDWait, StNWait, StFault} state_e;

  state_e             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [WIDTH-1:0]   ncl_t_q, ncl_t_d;
  logic [WIDTH-1:0]   ncl_f_q, ncl_f_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic               err_q, err_d;

  // Synchronizers for the asynchronous stage outputs.
  logic [SYNC_STAGES-1:0] ko_sync_q;
  logic [WIDTH-1:0]       res_t_sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]       res_f_sync_q [SYNC_STAGES];

  logic             ko_s;
  logic [WIDTH-1:0] res_t_s;
  logic [WIDTH-1:0] res_f_s;
  logic             d_done;
  logic             n_done;
  logic             rail_bad;
  logic             timed_out;
  logic             accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ko_sync_q <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        res_t_sync_q[i] <= '0;
        res_f_sync_q[i] <= '0;
      end
    end else begin
      ko_sync_q       <= {ko_sync_q[SYNC_STAGES-2:0], ncl_ko};
      res_t_sync_q[0] <= res_t;
      res_f_sync_q[0] <= res_f;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        res_t_sync_q[i] <= res_t_sync_q[i-1];
        res_f_sync_q[i] <= res_f_sync_q[i-1];
      end
    end
  end

  assign ko_s    = ko_sync_q[SYNC_STAGES-1];
  assign res_t_s = res_t_sync_q[SYNC_STAGES-1];
  assign res_f_s = res_f_sync_q[SYNC_STAGES-1];

  // DATA is complete when every pair has exactly one rail high; a pair with
  // both rails high fails the XOR and therefore reads as incomplete.
  assign d_done = ~ko_s & (&(res_t_s ^ res_f_s));
  assign n_done = ko_s & ~(|res_t_s) & ~(|res_f_s);

`ifdef NCL_RAIL_CHECK_EN
  assign rail_bad = |(res_t_s & res_f_s);
`else
  assign rail_bad = 1'b0;
`endif

  assign timed_out = (cnt_q == TimeoutCnt);
  assign in_ready  = (state_q == StIdle) & ko_s & ~out_valid_q;
  assign accept    = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ncl_t_d     = ncl_t_q;
    ncl_f_d     = ncl_f_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_data_d  = out_data_q;
    err_d       = err_q;

    unique case (state_q)
      StIdle: begin
        ncl_t_d = '0;
        ncl_f_d = '0;
        if (accept) begin
          state_d = StDWait;
          ncl_t_d = in_data;
          ncl_f_d = ~in_data;
          cnt_d   = '0;
        end
      end
      StDWait: begin
        // Completion is checked before the timeout so that a completion
        // landing on the limit cycle is still a normal capture.
        if (rail_bad) begin
          state_d = StFault;
          err_d   = 1'b1;
          ncl_t_d = '0;
          ncl_f_d = '0;
        end else if (d_done) begin
          state_d     = StNWait;
          out_data_d  = res_t_s;
          out_valid_d = 1'b1;
          ncl_t_d     = '0;
          ncl_f_d     = '0;
          cnt_d       = '0;
        end else if (timed_out) begin
          state_d = StFault;
          err_d   = 1'b1;
          ncl_t_d = '0;
          ncl_f_d = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StNWait: begin
        ncl_t_d = '0;
        ncl_f_d = '0;
        if (rail_bad) begin
          state_d = StFault;
          err_d   = 1'b1;
        end else if (n_done) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = StFault;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StFault: begin
        // Terminal until reset; a pending result may still drain.
        ncl_t_d = '0;
        ncl_f_d = '0;
        err_d   = 1'b1;
      end
      default: begin
        state_d = StFault;
        err_d   = 1'b1;
        ncl_t_d = '0;
        ncl_f_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ncl_t_q     <= '0;
      ncl_f_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ncl_t_q     <= ncl_t_d;
      ncl_f_q     <= ncl_f_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      err_q       <= err_d;
    end
  end

  assign ncl_t     = ncl_t_q;
  assign ncl_f     = ncl_f_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ncl_wavefront_ctrl.sv
// Directed bench for ncl_wavefront_ctrl (WIDTH=4, TIMEOUT=15, SYNC_STAGES=2).
// The NCL stage is modelled as a delay line on the rails: the stage output
// equals the rails as they were tap+1 cycles earlier, and ko is high while that
// output is NULL. hold_ko forces ko high; rail_fault forces bit 1 to both rails.
module tb_ncl_wavefront_ctrl;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic [3:0] ncl_t;
  logic [3:0] ncl_f;
  logic       ncl_ko;
  logic [3:0] res_t;
  logic [3:0] res_f;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       err;

  int total;
  int bad;

  // Stage model controls
  int   tap;
  logic hold_ko;
  logic rail_fault;

  logic [7:0] pipe [16];
  logic [7:0] stage;
  logic [3:0] st;
  logic [3:0] sf;

  ncl_wavefront_ctrl #(
    .WIDTH       (4),
    .TIMEOUT     (15),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .ncl_t     (ncl_t),
    .ncl_f     (ncl_f),
    .ncl_ko    (ncl_ko),
    .res_t     (res_t),
    .res_f     (res_f),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {ncl_t, ncl_f};
      for (int i = 1; i < 16; i++) pipe[i] <= pipe[i-1];
    end
  end

  always_comb begin
    stage = pipe[tap];
    st    = stage[7:4];
    sf    = stage[3:0];
  end

  assign ncl_ko = hold_ko | ~(|(st | sf));
  assign res_t  = st | (rail_fault ? 4'b0010 : 4'b0000);
  assign res_f  = sf | (rail_fault ? 4'b0010 : 4'b0000);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    hold_ko    = 1'b0;
    rail_fault = 1'b0;
    tap        = 1;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
  endtask

  // Presents d and returns just after the accepting edge, with in_valid low.
  task automatic accept(input logic [3:0] d);
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && in_ready !== 1'b1; i++) tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait in_ready=%b want=1", in_ready);
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    hold_ko    = 1'b0;
    rail_fault = 1'b0;
    tap        = 1;
    tick;
    tick;
    total++;
    if ({ncl_t, ncl_f} !== 8'h00) begin
      bad++; $display("FAIL reset_rails got=%h want=00", {ncl_t, ncl_f});
    end
    total++;
    if ({out_valid, out_data, err, in_ready} !== 7'b0) begin
      bad++; $display("FAIL reset_outs got=%b want=0000000", {out_valid, out_data, err, in_ready});
    end
    rst_n = 1'b1;
    tick;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_sync1 in_ready=%b want=0", in_ready);
    end
    tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_sync2 in_ready=%b want=1", in_ready);
    end
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    accept(4'hA);
    total++;
    if ({ncl_t, ncl_f} !== 8'hA5) begin
      bad++; $display("FAIL basic_rails got=%h want=a5", {ncl_t, ncl_f});
    end
    repeat (4) tick;
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL basic_early out_valid=%b want=0", out_valid);
    end
    tick;
    total++;
    if ({out_valid, out_data, ncl_t, ncl_f} !== 13'b1_1010_0000_0000) begin
      bad++; $display("FAIL basic_capture got=%b want=1101000000000",
                      {out_valid, out_data, ncl_t, ncl_f});
    end
    repeat (4) tick;
    total++;
    if ({in_ready, out_valid} !== 2'b00) begin
      bad++; $display("FAIL basic_nwait got=%b want=00", {in_ready, out_valid});
    end
    tick;
    total++;
    if ({in_ready, err} !== 2'b10) begin
      bad++; $display("FAIL basic_idle got=%b want=10", {in_ready, err});
    end
  endtask

  task automatic test_backpressure;
    int hold_bad;
    out_ready = 1'b0;
    accept(4'h3);
    in_data  = 4'hC;
    in_valid = 1'b1;
    repeat (5) tick;
    total++;
    if ({out_valid, out_data} !== 5'b1_0011) begin
      bad++; $display("FAIL bp_capture got=%b want=10011", {out_valid, out_data});
    end
    hold_bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      total++;
      if ({out_valid, out_data, in_ready, ncl_t} !== 10'b1_0011_0_0000) begin
        bad++; hold_bad++;
        $display("FAIL bp_hold cycle=%0d got=%b want=1001100000", i,
                 {out_valid, out_data, in_ready, ncl_t});
      end
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL bp_drain got=%b want=01", {out_valid, in_ready});
    end
    tick;
    in_valid = 1'b0;
    total++;
    if ({ncl_t, ncl_f} !== 8'hC3) begin
      bad++; $display("FAIL bp_second_rails got=%h want=c3", {ncl_t, ncl_f});
    end
    out_ready = 1'b1;
    repeat (5) tick;
    total++;
    if ({out_valid, out_data} !== 5'b1_1100) begin
      bad++; $display("FAIL bp_second_data got=%b want=11100", {out_valid, out_data});
    end
    repeat (5) tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_idle in_ready=%b want=1", in_ready);
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    accept(4'h1);
    in_data  = 4'h2;
    in_valid = 1'b1;
    repeat (9) tick;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL b2b_busy in_ready=%b want=0", in_ready);
    end
    tick;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL b2b_ready in_ready=%b want=1", in_ready);
    end
    tick;
    in_valid = 1'b0;
    total++;
    if ({ncl_t, ncl_f} !== 8'h2D) begin
      bad++; $display("FAIL b2b_rails got=%h want=2d", {ncl_t, ncl_f});
    end
    repeat (10) tick;
    total++;
    if ({out_data, in_ready, err} !== 6'b0010_1_0) begin
      bad++; $display("FAIL b2b_done got=%b want=001010", {out_data, in_ready, err});
    end
  endtask

  task automatic test_data_timeout;
    out_ready = 1'b1;
    hold_ko   = 1'b1;
    accept(4'h5);
    repeat (15) tick;
    total++;
    if ({err, ncl_t} !== 5'b0_0101) begin
      bad++; $display("FAIL to_before got=%b want=00101", {err, ncl_t});
    end
    tick;
    total++;
    if ({err, ncl_t, ncl_f, in_ready} !== 10'b1_0000_0000_0) begin
      bad++; $display("FAIL to_fault got=%b want=1000000000", {err, ncl_t, ncl_f, in_ready});
    end
    in_data  = 4'h7;
    in_valid = 1'b1;
    repeat (5) tick;
    total++;
    if ({err, in_ready, ncl_t} !== 6'b1_0_0000) begin
      bad++; $display("FAIL to_stuck got=%b want=100000", {err, in_ready, ncl_t});
    end
    do_reset;
  endtask

  task automatic test_async_reset;
    out_ready = 1'b1;
    accept(4'hF);
    tick;
    total++;
    if (ncl_t !== 4'hF) begin
      bad++; $display("FAIL ar_pre ncl_t=%h want=f", ncl_t);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({ncl_t, ncl_f, out_valid, err} !== 10'b0) begin
      bad++; $display("FAIL ar_rails got=%b want=0000000000", {ncl_t, ncl_f, out_valid, err});
    end
    tick;
    rst_n = 1'b1;
    accept(4'h6);
    repeat (5) tick;
    total++;
    if ({out_valid, out_data} !== 5'b1_0110) begin
      bad++; $display("FAIL ar_resume got=%b want=10110", {out_valid, out_data});
    end
    repeat (5) tick;
    out_ready = 1'b0;
    accept(4'h9);
    repeat (5) tick;
    total++;
    if ({out_valid, out_data} !== 5'b1_1001) begin
      bad++; $display("FAIL ar_pending got=%b want=11001", {out_valid, out_data});
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({out_valid, out_data} !== 5'b0) begin
      bad++; $display("FAIL ar_discard got=%b want=00000", {out_valid, out_data});
    end
    tick;
    rst_n = 1'b1;
    tick;
    tick;
    tick;
  endtask

  task automatic test_rail_check;
    out_ready = 1'b1;
    tap       = 1;
    accept(4'h7);
    rail_fault = 1'b1;
`ifdef NCL_RAIL_CHECK_EN
    tick;
    tick;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL rc_early err=%b want=0", err);
    end
    tick;
    total++;
    if ({err, ncl_t, ncl_f} !== 9'b1_0000_0000) begin
      bad++; $display("FAIL rc_fault got=%b want=100000000", {err, ncl_t, ncl_f});
    end
`else
    repeat (15) tick;
    total++;
    if (err !== 1'b0) begin
      bad++; $display("FAIL rc_early err=%b want=0", err);
    end
    tick;
    total++;
    if ({err, ncl_t, ncl_f} !== 9'b1_0000_0000) begin
      bad++; $display("FAIL rc_timeout got=%b want=100000000", {err, ncl_t, ncl_f});
    end
`endif
    do_reset;
  endtask

  task automatic test_limit;
    out_ready = 1'b1;
    tap       = 12;
    accept(4'h9);
    repeat (15) tick;
    total++;
    if ({out_valid, err} !== 2'b00) begin
      bad++; $display("FAIL lim_before got=%b want=00", {out_valid, err});
    end
    tick;
    total++;
    if ({out_valid, out_data, err} !== 6'b1_1001_0) begin
      bad++; $display("FAIL lim_capture got=%b want=110010", {out_valid, out_data, err});
    end
    repeat (15) tick;
    total++;
    if (in_ready !== 1'b0) begin
      bad++; $display("FAIL lim_nwait in_ready=%b want=0", in_ready);
    end
    tick;
    total++;
    if ({in_ready, err} !== 2'b10) begin
      bad++; $display("FAIL lim_null got=%b want=10", {in_ready, err});
    end
    tap = 13;
    accept(4'h4);
    repeat (16) tick;
    total++;
    if ({err, out_valid} !== 2'b10) begin
      bad++; $display("FAIL lim_over got=%b want=10", {err, out_valid});
    end
    do_reset;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset;
    test_basic;
    test_backpressure;
    test_back_to_back;
    test_data_timeout;
    test_async_reset;
    test_rail_check;
    test_limit;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
